// File: rtl/alu_writeback_if.sv
// ALU-outcome intake channel and register-file write channel of the writeback stage.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on intake, wb_valid/wb_ready on the register write port.
//
// Ports / signals:
//   in_valid, in_ready            intake handshake (in_ready driven by the stage)
//   in_dest, in_write_result,
//   in_update_flags, in_result,
//   in_zero/in_carry/in_negitive,
//   in_div_by_zero                ALU outcome payload
//   wb_valid, wb_ready            register-file write handshake (wb_ready driven by the regfile)
//   wb_dest, wb_data              head-of-buffer write
// Modports: master = ALU + register file side, slave = writeback stage.
interface alu_writeback_if #(
  parameter int REG_ADDR_W = 5
);
  // ALU outcome channel
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_dest;
  logic                  in_write_result;
  logic                  in_update_flags;
  logic [63:0]           in_result;
  logic                  in_zero;
  logic                  in_carry;
  logic                  in_negitive;
  logic                  in_div_by_zero;

  // Register-file write channel
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [63:0]           wb_data;

  modport master (
    output in_valid, in_dest, in_write_result, in_update_flags, in_result,
           in_zero, in_carry, in_negitive, in_div_by_zero, wb_ready,
    input  in_ready, wb_valid, wb_dest, wb_data
  );

  modport slave (
    input  in_valid, in_dest, in_write_result, in_update_flags, in_result,
           in_zero, in_carry, in_negitive, in_div_by_zero, wb_ready,
    output in_ready, wb_valid, wb_dest, wb_data
  );
endinterface

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: commits ALU flags, buffers register writes (2 deep), raises a sticky div-by-zero fault.
// Latency: accepted write/flags visible one cycle after the accepting edge.
// Backpressure: in_ready = buffer not full and no fault, from registered state only; buffer drains on wb_ready.
//
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   bus (slave)     ALU outcome intake (in_*) and register-file write port (wb_*)
//   flag_zero/flag_carry/flag_negitive  architectural flags; flag_carry feeds the ALU carry input
//   fault, fault_dest  sticky divide-by-zero fault and the destination of the faulting op
//   fault_clear     clears the fault (no effect when no fault is pending)
module alu_writeback #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_writeback_if.slave        bus,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  flag_negitive,
  output logic                  fault,
  output logic [REG_ADDR_W-1:0] fault_dest,
  input  logic                  fault_clear
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [63:0]           data;
  } wb_entry_t;

  // Buffer state: head is always the oldest entry, tail the second one.
  logic [1:0]            count_q, count_d;
  wb_entry_t             head_q, head_d;
  wb_entry_t             tail_q, tail_d;

  logic                  flag_zero_q, flag_zero_d;
  logic                  flag_carry_q, flag_carry_d;
  logic                  flag_negitive_q, flag_negitive_d;
  logic                  fault_q, fault_d;
  logic [REG_ADDR_W-1:0] fault_dest_q, fault_dest_d;

  logic                  in_ready_int;
  logic                  accept;
  logic                  div_fault;
  logic                  enq;
  logic                  deq;
  wb_entry_t             new_entry;

  // Registered-state-only ready: no path from in_valid or wb_ready.
  assign in_ready_int = (count_q != 2'd2) && !fault_q;
  assign accept       = bus.in_valid && in_ready_int;
  assign div_fault    = accept && bus.in_div_by_zero;
  assign enq          = accept && !bus.in_div_by_zero && bus.in_write_result;
  assign deq          = (count_q != 2'd0) && bus.wb_ready;

  assign new_entry.dest = bus.in_dest;
  assign new_entry.data = bus.in_result;

  // Buffer next state
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({enq, deq})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = new_entry;
        end else begin
          tail_d = new_entry;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with count_q == 1 (enqueue needs count < 2): the
        // head leaves and the new entry takes its place.
        head_d = new_entry;
      end
      default: begin
      end
    endcase
  end

  // Flags and fault next state
  always_comb begin
    flag_zero_d     = flag_zero_q;
    flag_carry_d    = flag_carry_q;
    flag_negitive_d = flag_negitive_q;
    fault_d         = fault_q;
    fault_dest_d    = fault_dest_q;

    if (accept && !bus.in_div_by_zero && bus.in_update_flags) begin
      flag_zero_d     = bus.in_zero;
      flag_carry_d    = bus.in_carry;
      flag_negitive_d = bus.in_negitive;
    end

    // An accept implies no pending fault, so set and clear never collide.
    if (div_fault) begin
      fault_d      = 1'b1;
      fault_dest_d = bus.in_dest;
    end else if (fault_clear && fault_q) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q         <= 2'd0;
      head_q          <= '0;
      tail_q          <= '0;
      flag_zero_q     <= 1'b0;
      flag_carry_q    <= 1'b0;
      flag_negitive_q <= 1'b0;
      fault_q         <= 1'b0;
      fault_dest_q    <= '0;
    end else begin
      count_q         <= count_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      flag_zero_q     <= flag_zero_d;
      flag_carry_q    <= flag_carry_d;
      flag_negitive_q <= flag_negitive_d;
      fault_q         <= fault_d;
      fault_dest_q    <= fault_dest_d;
    end
  end

  assign bus.in_ready = in_ready_int;
  assign bus.wb_valid = (count_q != 2'd0);
  assign bus.wb_dest  = head_q.dest;
  assign bus.wb_data  = head_q.data;

  assign flag_zero     = flag_zero_q;
  assign flag_carry    = flag_carry_q;
  assign flag_negitive = flag_negitive_q;
  assign fault         = fault_q;
  assign fault_dest    = fault_dest_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flag_zero, flag_carry, flag_negitive;
  logic          fault;
  logic [AW-1:0] fault_dest;
  logic          fault_clear;

  int checks = 0;
  int errors = 0;

  alu_writeback_if #(.REG_ADDR_W(AW)) bus ();

  alu_writeback #(.REG_ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .flag_negitive(flag_negitive),
    .fault        (fault),
    .fault_dest   (fault_dest),
    .fault_clear  (fault_clear)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] dest;
    logic [63:0]   data;
  } ent_t;

  ent_t          m_q[$];
  logic          m_z = 1'b0, m_c = 1'b0, m_n = 1'b0;
  logic          m_fault = 1'b0;
  logic [AW-1:0] m_fdest = '0;
  int            m_accepts = 0;
  int            m_pushes = 0;
  bit            m_rdy, m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
      m_fault = 1'b0;
      m_fdest = '0;
    end else begin
      m_rdy = (m_q.size() < 2) && !m_fault;
      m_acc = bus.in_valid && m_rdy;
      if (m_q.size() != 0 && bus.wb_ready) void'(m_q.pop_front());
      if (m_fault && fault_clear) m_fault = 1'b0;
      if (m_acc) begin
        m_accepts++;
        if (bus.in_div_by_zero) begin
          m_fault = 1'b1;
          m_fdest = bus.in_dest;
        end else begin
          if (bus.in_update_flags) begin
            m_z = bus.in_zero; m_c = bus.in_carry; m_n = bus.in_negitive;
          end
          if (bus.in_write_result) begin
            m_q.push_back({bus.in_dest, bus.in_result});
            m_pushes++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_op(input logic v, input logic [AW-1:0] d, input logic wr, input logic up,
                          input logic [63:0] r, input logic z, input logic c, input logic n,
                          input logic dz);
    bus.in_valid        = v;
    bus.in_dest         = d;
    bus.in_write_result = wr;
    bus.in_update_flags = up;
    bus.in_result       = r;
    bus.in_zero         = z;
    bus.in_carry        = c;
    bus.in_negitive     = n;
    bus.in_div_by_zero  = dz;
  endtask

  task automatic idle();
    drive_op(1'b0, '0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data, flag_zero, flag_carry, flag_negitive, fault, fault_dest} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wb_valid=%b dest=%h data=%h flags=%b%b%b fault=%b fdest=%h want all 0",
               bus.wb_valid, bus.wb_dest, bus.wb_data, flag_zero, flag_carry, flag_negitive, fault, fault_dest);
    end
  endtask

  task automatic test_basic();
    bus.wb_ready = 1'b1;
    drive_op(1'b1, 5'd3, 1'b1, 1'b1, 64'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    checks++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data} !== {1'b1, 5'd3, 64'h1234}) begin
      errors++; $display("FAIL basic_wb: got v=%b dest=%0d data=%h want v=1 dest=3 data=1234",
                         bus.wb_valid, bus.wb_dest, bus.wb_data);
    end
    checks++;
    if (flag_carry !== 1'b1) begin
      errors++; $display("FAIL basic_carry: got %b want 1", flag_carry);
    end
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drained: wb_valid got %b want 0", bus.wb_valid);
    end
  endtask

  task automatic test_backpressure();
    ent_t got[$];
    ent_t exp[3];
    bit   take;
    int   budget;
    exp[0] = {5'd1, 64'hA};
    exp[1] = {5'd2, 64'hB};
    exp[2] = {5'd4, 64'hC};
    bus.wb_ready = 1'b0;
    drive_op(1'b1, 5'd1, 1'b1, 1'b0, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(1'b1, 5'd2, 1'b1, 1'b0, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready);
    end
    drive_op(1'b1, 5'd4, 1'b1, 1'b0, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.wb_data} !== {1'b0, 64'hA}) begin
      errors++; $display("FAIL bp_hold: got ready=%b data=%h want ready=0 data=a", bus.in_ready, bus.wb_data);
    end
    if (bus.wb_valid) got.push_back({bus.wb_dest, bus.wb_data});
    bus.wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_after_deq: got %b want 1", bus.in_ready);
    end
    take = 1'b0;
    budget = 0;
    while (got.size() < 3 && budget < 12) begin
      take = bus.in_valid && bus.in_ready;
      if (bus.wb_valid) got.push_back({bus.wb_dest, bus.wb_data});
      @(negedge clk);
      if (take) idle();
      budget++;
    end
    idle();
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL bp_count: got %0d entries want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], exp[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup: wb_valid got %b want 0", bus.wb_valid);
    end
  endtask

  task automatic test_flags();
    // flags before: zero=0 carry=1 neg=0
    drive_op(1'b1, 5'd6, 1'b0, 1'b1, 64'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    checks++;
    if ({bus.wb_valid, flag_zero, flag_carry, flag_negitive} !== 4'b0100) begin
      errors++; $display("FAIL cmp_flags: got v=%b zcn=%b%b%b want v=0 zcn=100",
                         bus.wb_valid, flag_zero, flag_carry, flag_negitive);
    end
    drive_op(1'b1, 5'd6, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    idle();
    checks++;
    if ({bus.wb_valid, flag_zero, flag_carry, flag_negitive} !== 4'b0100) begin
      errors++; $display("FAIL noupd_flags: got v=%b zcn=%b%b%b want v=0 zcn=100",
                         bus.wb_valid, flag_zero, flag_carry, flag_negitive);
    end
  endtask

  task automatic test_div_zero();
    bus.wb_ready = 1'b0;
    drive_op(1'b1, 5'd2, 1'b1, 1'b0, 64'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(1'b1, 5'd7, 1'b1, 1'b1, 64'h99, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    idle();
    checks++;
    if ({fault, fault_dest, bus.in_ready} !== {1'b1, 5'd7, 1'b0}) begin
      errors++; $display("FAIL dbz_fault: got fault=%b fdest=%0d ready=%b want 1 7 0", fault, fault_dest, bus.in_ready);
    end
    checks++;
    if ({bus.wb_valid, bus.wb_data, flag_zero, flag_carry, flag_negitive} !== {1'b1, 64'h55, 3'b100}) begin
      errors++; $display("FAIL dbz_noenq: got v=%b data=%h zcn=%b%b%b want v=1 data=55 zcn=100",
                         bus.wb_valid, bus.wb_data, flag_zero, flag_carry, flag_negitive);
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.wb_valid, fault, bus.in_ready} !== 3'b010) begin
      errors++; $display("FAIL dbz_drain: got v=%b fault=%b ready=%b want 0 1 0", bus.wb_valid, fault, bus.in_ready);
    end
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    checks++;
    if ({fault, bus.in_ready, fault_dest} !== {1'b0, 1'b1, 5'd7}) begin
      errors++; $display("FAIL dbz_clear: got fault=%b ready=%b fdest=%0d want 0 1 7", fault, bus.in_ready, fault_dest);
    end
  endtask

  task automatic test_async_reset();
    // Phase 1: buffer full
    bus.wb_ready = 1'b0;
    drive_op(1'b1, 5'd8, 1'b1, 1'b1, 64'h111, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive_op(1'b1, 5'd9, 1'b1, 1'b0, 64'h222, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    checks++;
    if ({bus.wb_valid, bus.in_ready} !== 2'b10) begin
      errors++; $display("FAIL ar_full: got v=%b ready=%b want 1 0", bus.wb_valid, bus.in_ready);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.wb_valid, bus.wb_data, flag_zero, flag_carry, flag_negitive, fault} !== '0) begin
      errors++; $display("FAIL ar_full_clear: got v=%b data=%h zcn=%b%b%b fault=%b want all 0",
                         bus.wb_valid, bus.wb_data, flag_zero, flag_carry, flag_negitive, fault);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.wb_valid} !== 2'b10) begin
      errors++; $display("FAIL ar_full_release: got ready=%b v=%b want 1 0", bus.in_ready, bus.wb_valid);
    end
    // Phase 2: pending entry plus fault
    drive_op(1'b1, 5'd5, 1'b1, 1'b1, 64'h333, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(1'b1, 5'd9, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    idle();
    checks++;
    if ({fault, bus.wb_valid, flag_carry} !== 3'b111) begin
      errors++; $display("FAIL ar_fault_set: got fault=%b v=%b carry=%b want 1 1 1", fault, bus.wb_valid, flag_carry);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({fault, fault_dest, bus.wb_valid, bus.wb_dest, flag_zero, flag_carry, flag_negitive} !== '0) begin
      errors++; $display("FAIL ar_fault_clear: got fault=%b fdest=%0d v=%b dest=%0d zcn=%b%b%b want all 0",
                         fault, fault_dest, bus.wb_valid, bus.wb_dest, flag_zero, flag_carry, flag_negitive);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL ar_fault_release: in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_stream();
    int start_acc, start_push, start_size, deq_seen, cyc;
    start_acc  = m_accepts;
    start_push = m_pushes;
    start_size = m_q.size();
    deq_seen   = 0;
    cyc        = 0;
    while ((m_accepts - start_acc) < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (bus.in_ready !== ((m_q.size() < 2) && !m_fault)) begin
        errors++; $display("FAIL stream_ready @%0d: got %b want %b", cyc, bus.in_ready, (m_q.size() < 2) && !m_fault);
      end
      checks++;
      if (bus.wb_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL stream_valid @%0d: got %b want %b", cyc, bus.wb_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        checks++;
        if ({bus.wb_dest, bus.wb_data} !== m_q[0]) begin
          errors++; $display("FAIL stream_head @%0d: got %h want %h", cyc, {bus.wb_dest, bus.wb_data}, m_q[0]);
        end
      end
      checks++;
      if ({flag_zero, flag_carry, flag_negitive} !== {m_z, m_c, m_n}) begin
        errors++; $display("FAIL stream_flags @%0d: got %b%b%b want %b%b%b", cyc,
                           flag_zero, flag_carry, flag_negitive, m_z, m_c, m_n);
      end
      checks++;
      if ({fault, fault_dest} !== {m_fault, m_fdest}) begin
        errors++; $display("FAIL stream_fault @%0d: got %b/%0d want %b/%0d", cyc, fault, fault_dest, m_fault, m_fdest);
      end
      drive_op(1'($urandom_range(0, 3) != 0), AW'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      bus.wb_ready = 1'($urandom_range(0, 1));
      fault_clear  = m_fault && ($urandom_range(0, 2) == 0);
      if (bus.wb_valid && bus.wb_ready) deq_seen++;
    end
    if (cyc >= 3000) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d accepts want 100", m_accepts - start_acc);
    end
    idle();
    fault_clear  = 1'b0;
    bus.wb_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m_q.size() != 0) begin
        checks++;
        if ({bus.wb_dest, bus.wb_data} !== m_q[0]) begin
          errors++; $display("FAIL drain_head: got %h want %h", {bus.wb_dest, bus.wb_data}, m_q[0]);
        end
      end
      if (bus.wb_valid) deq_seen++;
    end
    checks++;
    if (deq_seen != start_size + (m_pushes - start_push)) begin
      errors++; $display("FAIL stream_writes: got %0d dequeues want %0d", deq_seen, start_size + (m_pushes - start_push));
    end
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL stream_empty: wb_valid got %b want 0", bus.wb_valid);
    end
  endtask

  initial begin
    reset        = 1'b1;
    fault_clear  = 1'b0;
    bus.wb_ready = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_flags();
    test_div_zero();
    test_async_reset();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
